// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path constants for the RISC core: FSM state encodings and opcode width.
package cpu_ctrl_pkg;

    localparam int OPCODE_W = 4;
    localparam int STATE_W  = 3;

    localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 4'hF;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_PCUPD  = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: memory handshake, IR load, execute hand-off, PC update.
// state | meaning: IDLE wait run_en | FETCH mem_req | LOAD ldir | DECODE opcode | EXEC wait done | PCUPD pc_inc/pc_load | HALT | FAULT
module fetch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int                  MEM_TIMEOUT = 16,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
    parameter int                  CNT_W       = 16,
    parameter int                  TMR_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_en,
    input  logic                mem_ack,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                exec_done,
    input  logic                branch_taken,
    output logic                mem_req,
    output logic                ldir,
    output logic                exec_start,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                halted,
    output logic                fault,
    output logic [CNT_W-1:0]    retired,
    output logic [STATE_W-1:0]  state_dbg
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_retired;
    logic               r_exec_start;
    logic               r_branch;
    logic               w_timer_exp;

    assign w_timer_exp = (r_timer == TMR_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An ack on the expiry cycle still completes the fetch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run_en) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack)          w_state_nxt = ST_LOAD;
                else if (w_timer_exp) w_state_nxt = ST_FAULT;
            end
            ST_LOAD:   w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (opcode == HALT_OPCODE) w_state_nxt = ST_HALT;
                else                       w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_done) w_state_nxt = ST_PCUPD;
            end
            ST_PCUPD: begin
                if (run_en) w_state_nxt = ST_FETCH;
                else        w_state_nxt = ST_IDLE;
            end
            ST_HALT:  w_state_nxt = ST_HALT;
            ST_FAULT: w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Timer counts FETCH cycles and restarts from zero on every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if ((r_state == ST_FETCH) && (w_state_nxt == ST_FETCH)) begin
            r_timer <= r_timer + TMR_W'(1);
        end else begin
            r_timer <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exec_start <= 1'b0;
            r_branch     <= 1'b0;
            r_retired    <= '0;
        end else begin
            r_exec_start <= (r_state == ST_DECODE) && (w_state_nxt == ST_EXEC);
            if ((r_state == ST_EXEC) && exec_done) begin
                r_branch <= branch_taken;
            end
            if (r_state == ST_PCUPD) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        ldir       = 1'b0;
        exec_start = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        case (r_state)
            ST_FETCH: mem_req    = 1'b1;
            ST_LOAD:  ldir       = 1'b1;
            ST_EXEC:  exec_start = r_exec_start;
            ST_PCUPD: begin
                pc_inc  = ~r_branch;
                pc_load = r_branch;
            end
            ST_HALT:  halted = 1'b1;
            ST_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

    assign retired   = r_retired;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a cycle model pushes expected outputs, DUT samples pop them.
module tb_fetch_sequencer;

    localparam int MT = 4;
    localparam int CW = 2;
    localparam int M_IDLE = 0, M_FETCH = 1, M_LOAD = 2, M_DECODE = 3;
    localparam int M_EXEC = 4, M_PCUPD = 5, M_HALT = 6, M_FAULT = 7;

    logic          clk = 1'b0;
    logic          rst, run_en, mem_ack, exec_done, branch_taken;
    logic [3:0]    opcode;
    logic          mem_req, ldir, exec_start, pc_inc, pc_load, halted, fault;
    logic [CW-1:0] retired;
    logic [2:0]    state_dbg;

    fetch_sequencer #(
        .MEM_TIMEOUT(MT), .HALT_OPCODE(4'hF), .CNT_W(CW), .TMR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .mem_ack(mem_ack), .opcode(opcode),
        .exec_done(exec_done), .branch_taken(branch_taken), .mem_req(mem_req),
        .ldir(ldir), .exec_start(exec_start), .pc_inc(pc_inc), .pc_load(pc_load),
        .halted(halted), .fault(fault), .retired(retired), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] outs;
        int         st;
        int         ret;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    int   m_st, m_tmr, m_ret, m_ecnt;
    bit   m_xs, m_br;
    bit   ack_en;
    int   ack_delay, done_delay;
    logic [3:0] cfg_op;
    logic cfg_br;
    int   c_mreq, c_ldir, c_xs, c_inc, c_load, c_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit xs_n;
        xs_n = 1'b0;
        if (rst) begin
            m_st = M_IDLE; m_tmr = 0; m_ret = 0; m_br = 1'b0; m_ecnt = 0;
        end else begin
            case (m_st)
                M_IDLE:   if (run_en) m_st = M_FETCH;
                M_FETCH: begin
                    if (mem_ack) begin
                        m_st = M_LOAD; m_tmr = 0;
                    end else if (m_tmr == MT - 1) begin
                        m_st = M_FAULT; m_tmr = 0;
                    end else begin
                        m_tmr++;
                    end
                end
                M_LOAD:   m_st = M_DECODE;
                M_DECODE: begin
                    if (opcode == 4'hF) m_st = M_HALT;
                    else begin
                        m_st = M_EXEC; xs_n = 1'b1; m_ecnt = 0;
                    end
                end
                M_EXEC: begin
                    if (exec_done) begin
                        m_br = branch_taken; m_st = M_PCUPD;
                    end else begin
                        m_ecnt++;
                    end
                end
                M_PCUPD: begin
                    m_ret = (m_ret + 1) % (1 << CW);
                    m_st  = run_en ? M_FETCH : M_IDLE;
                end
                default: ;
            endcase
        end
        m_xs = xs_n;
    endtask

    task automatic cyc();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("outs", 32'({mem_req, ldir, exec_start, pc_inc, pc_load, halted, fault}), 32'(e.outs));
            chk("state_dbg", 32'(state_dbg), 32'(e.st));
            chk("retired", 32'(retired), 32'(e.ret));
            chk("pulse_excl", 32'($countones({ldir, exec_start, pc_inc, pc_load}) <= 1), 32'(1));
            c_mreq  += int'(mem_req);
            c_ldir  += int'(ldir);
            c_xs    += int'(exec_start);
            c_inc   += int'(pc_inc);
            c_load  += int'(pc_load);
            c_fault += int'(fault);
        end
        mem_ack      = ack_en && (m_st == M_FETCH) && (m_tmr == ack_delay);
        exec_done    = (m_st == M_EXEC) && (m_ecnt == done_delay);
        opcode       = cfg_op;
        branch_taken = cfg_br;
        model_step();
        e.outs = {m_st == M_FETCH, m_st == M_LOAD, m_xs, (m_st == M_PCUPD) && !m_br,
                  (m_st == M_PCUPD) && m_br, m_st == M_HALT, m_st == M_FAULT};
        e.st   = m_st;
        e.ret  = m_ret;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr();
        c_mreq = 0; c_ldir = 0; c_xs = 0; c_inc = 0; c_load = 0; c_fault = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; run_en = 1'b0;
        repeat (n) cyc();
        rst = 1'b0;
        clr();
    endtask

    task automatic wait_state(input int s, input int lim, input string tag);
        int k;
        k = 0;
        while (m_st != s && k < lim) begin
            cyc();
            k++;
        end
        chk(tag, 32'(state_dbg), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[$];
        int exp_seq[5];
        int prev, k;

        rst = 1'b1; run_en = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
        branch_taken = 1'b0; opcode = 4'h0;
        ack_en = 1'b1; ack_delay = 0; done_delay = 0; cfg_op = 4'hA; cfg_br = 1'b0;
        m_st = 0; m_tmr = 0; m_ret = 0; m_ecnt = 0; m_xs = 1'b0; m_br = 1'b0;
        clr();
        @(negedge clk);

        // Reset then one minimum-latency instruction
        do_reset(2);
        chk("rst_state", 32'(state_dbg), 32'(0));
        chk("rst_retired", 32'(retired), 32'(0));
        run_en = 1'b1; cyc(); run_en = 1'b0;
        repeat (5) cyc();
        chk("s1_retired", 32'(retired), 32'(1));
        chk("s1_state", 32'(state_dbg), 32'(M_IDLE));
        chk("s1_mreq_cnt", 32'(c_mreq), 32'(1));
        chk("s1_ldir_cnt", 32'(c_ldir), 32'(1));
        chk("s1_xs_cnt", 32'(c_xs), 32'(1));
        chk("s1_inc_cnt", 32'(c_inc), 32'(1));
        chk("s1_load_cnt", 32'(c_load), 32'(0));
        cyc();

        // Memory wait: ack on the expiry cycle still wins
        do_reset(1);
        ack_delay = 3;
        run_en = 1'b1; cyc(); run_en = 1'b0;
        repeat (9) cyc();
        chk("s2_mreq_cnt", 32'(c_mreq), 32'(4));
        chk("s2_ldir_cnt", 32'(c_ldir), 32'(1));
        chk("s2_fault_cnt", 32'(c_fault), 32'(0));
        chk("s2_retired", 32'(retired), 32'(1));

        // Timeout into FAULT, then recover by reset
        do_reset(1);
        ack_en = 1'b0;
        run_en = 1'b1; cyc(); run_en = 1'b0;
        repeat (7) cyc();
        chk("s3_mreq_cnt", 32'(c_mreq), 32'(4));
        chk("s3_fault", 32'(fault), 32'(1));
        chk("s3_state", 32'(state_dbg), 32'(M_FAULT));
        chk("s3_mreq_now", 32'(mem_req), 32'(0));
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("s3_rst_state", 32'(state_dbg), 32'(M_IDLE));
        chk("s3_rst_fault", 32'(fault), 32'(0));
        cyc();

        // Branch then halt
        do_reset(1);
        ack_en = 1'b1; ack_delay = 0; done_delay = 1; cfg_op = 4'hA; cfg_br = 1'b1;
        run_en = 1'b1;
        wait_state(M_PCUPD, 20, "s4_reach_pcupd");
        cfg_op = 4'hF; cfg_br = 1'b0;
        repeat (8) cyc();
        chk("s4_halted", 32'(halted), 32'(1));
        chk("s4_state", 32'(state_dbg), 32'(M_HALT));
        chk("s4_retired", 32'(retired), 32'(1));
        chk("s4_load_cnt", 32'(c_load), 32'(1));
        chk("s4_inc_cnt", 32'(c_inc), 32'(0));
        chk("s4_xs_cnt", 32'(c_xs), 32'(1));

        // run_en dropped during EXEC of the second instruction
        do_reset(1);
        cfg_op = 4'hA; cfg_br = 1'b0; done_delay = 2;
        run_en = 1'b1;
        k = 0;
        while (!(m_st == M_EXEC && m_ret == 1) && k < 30) begin
            cyc();
            k++;
        end
        chk("s5_reach_exec2", 32'(state_dbg), 32'(M_EXEC));
        run_en = 1'b0;
        repeat (10) cyc();
        chk("s5_retired", 32'(retired), 32'(2));
        chk("s5_state", 32'(state_dbg), 32'(M_IDLE));
        chk("s5_mreq_now", 32'(mem_req), 32'(0));
        chk("s5_inc_cnt", 32'(c_inc), 32'(2));
        chk("s5_load_cnt", 32'(c_load), 32'(0));

        // Counter wrap over five instructions, then reset mid-FETCH
        do_reset(1);
        cfg_op = 4'h5; ack_delay = 1; done_delay = 1;
        run_en = 1'b1;
        exp_seq = '{1, 2, 3, 0, 1};
        prev = 0;
        k = 0;
        while (seq.size() < 5 && k < 100) begin
            cyc();
            k++;
            if (int'(retired) != prev) begin
                prev = int'(retired);
                seq.push_back(prev);
            end
        end
        chk("s6_seq_len", 32'(seq.size()), 32'(5));
        foreach (seq[i]) chk($sformatf("s6_seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        wait_state(M_FETCH, 20, "s6_reach_fetch");
        rst = 1'b1; cyc(); rst = 1'b0; run_en = 1'b0;
        chk("s6_rst_state", 32'(state_dbg), 32'(M_IDLE));
        chk("s6_rst_mreq", 32'(mem_req), 32'(0));
        chk("s6_rst_retired", 32'(retired), 32'(0));
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle control FSM that sequences instruction fetch for the 32-bit RISC core. It handshakes with instruction memory and pulses ldir into the instruction register. It then reads the 4-bit opcode back from the IR, hands the instruction to the execute stage, and finally commands the PC to increment or load a branch target. It sits between the memory interface, instruction_register, PC and execute unit, and is the sole driver of ldir.

Parameters:
MEM_TIMEOUT, 16, max FETCH cycles waiting for mem_ack before entering FAULT (min 2)
HALT_OPCODE, 4'hF, opcode value that stops the sequencer
CNT_W, 16, width of retired-instruction counter
TMR_W, 8, width of fetch timeout timer (must hold MEM_TIMEOUT-1)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
run_en  in  1  permits starting a new fetch
mem_ack  in  1  instruction memory data valid on bus this cycle
opcode  in  4  opcode field from instruction_register
exec_done  in  1  execute unit finished current instruction
branch_taken  in  1  valid with exec_done: select PC load instead of increment
mem_req  out  1  instruction read request
ldir  out  1  load-enable to instruction_register
exec_start  out  1  one-cycle start pulse to execute unit
pc_inc  out  1  one-cycle PC increment
pc_load  out  1  one-cycle PC load of branch target
halted  out  1  sequencer in HALT
fault  out  1  sequencer in FAULT (fetch timeout)
retired  out  CNT_W  count of completed instructions
state_dbg  out  3  current state encoding

Behaviour:
- States and encodings: IDLE=0, FETCH=1, LOAD=2, DECODE=3, EXEC=4, PCUPD=5, HALT=6, FAULT=7.
- All outputs are Moore decodes of the registered state (plus the registered exec-start flag). There are no combinational paths from input to output.
- Reset (rst=1 at a clock edge) sets:
  - state=IDLE, timer=0, retired=0, exec-start flag=0.
  - All control outputs 0.
  - Reset overrides any state, including mid-handshake, HALT and FAULT.
- IDLE: run_en=1 -> FETCH; else stay.
- FETCH:
  - mem_req=1 for every cycle in FETCH. Timer starts at 0 on entry and increments each FETCH cycle.
  - mem_ack=1 -> LOAD; mem_req drops the next cycle.
  - No ack with timer==MEM_TIMEOUT-1 -> FAULT.
  - Ack in the same cycle as expiry: ack wins (-> LOAD).
- LOAD: ldir=1 for exactly one cycle; the IR captures the bus on this edge. -> DECODE.
- DECODE: opcode is valid (IR is registered).
  - opcode==HALT_OPCODE -> HALT.
  - Otherwise -> EXEC, with exec_start=1 for the first EXEC cycle only.
- EXEC: exec_done is sampled every EXEC cycle, including the first.
  - exec_done=1 -> PCUPD; branch_taken is captured in the same cycle.
  - Otherwise wait, with no timeout.
- PCUPD:
  - Exactly one of pc_load (captured branch_taken=1) or pc_inc (=0) is high for one cycle.
  - retired increments by 1, wrapping from 2^CNT_W-1 to 0.
  - Next state: run_en=1 -> FETCH; else IDLE.
- run_en deasserted mid-instruction: the instruction completes through PCUPD, then the sequencer goes to IDLE. run_en is only consulted in IDLE and PCUPD.
- HALT: halted=1 and all pulses are 0. Leave only by rst. HALT does not increment retired.
- FAULT: fault=1, mem_req=0. Leave only by rst.
- Minimum instruction latency with ack and done on their first cycles is 5 cycles (FETCH, LOAD, DECODE, EXEC, PCUPD). Back-to-back instructions are therefore 5 cycles apart.
- At most one of ldir, exec_start, pc_inc and pc_load is high in any cycle.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding constants (IDLE..FAULT)
  - HALT_OPCODE default
  - the opcode width constant 4, shared with instruction_register
- No sub-module is required. The timeout timer is a small counter inline; fetch_timer may be split out if reused by a data-memory controller.

Test Plan:
- Reset then run: rst=1 for 2 cycles, then rst=0 and run_en=1, mem_ack on the 1st FETCH cycle, opcode=4'hA, exec_done on the 1st EXEC cycle, branch_taken=0 -> single-cycle pulses mem_req, ldir, exec_start, pc_inc in consecutive states; retired=1 after 5 cycles.
- Memory wait: mem_ack delayed 3 cycles -> mem_req high for 4 cycles; ldir one cycle after the ack; no fault.
- Timeout: MEM_TIMEOUT=4, mem_ack never asserted -> mem_req high for 4 cycles, then fault=1, state_dbg=7; stays until rst=1 returns to IDLE with fault=0.
- Branch and halt: first instruction with branch_taken=1 and exec_done -> pc_load=1, pc_inc=0. Next opcode=4'hF -> halted=1, no exec_start, retired stays 1.
- run_en drop: run_en=0 during EXEC of the 2nd instruction -> PCUPD still pulses pc_inc, retired=2, then IDLE with no mem_req.
- Wrap and reset mid-op: CNT_W=2, run 5 instructions -> retired sequence 1,2,3,0,1. Then assert rst while in FETCH -> next cycle state=IDLE, mem_req=0, retired=0.
